// File: rtl/dmem_lsu.sv
// dmem_lsu: byte-addressed RV32I data memory with a valid/ready request,
// a one-cycle response pulse and LATENCY-cycle reads. Optional DMEM_CLEAR_EN.
module dmem_lsu #(
  parameter int DEPTH   = 256,
  parameter int LATENCY = 1,
  parameter int ADDR_W  = 32
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [2:0]        req_funct3,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  output logic              rsp_valid,
  output logic [31:0]       rsp_rdata,
  output logic              rsp_fault
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = (LATENCY > 1) ? $clog2(LATENCY) : 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_RESP,
    S_CLEAR
  } state_t;

`ifdef DMEM_CLEAR_EN
  localparam state_t RST_ST = S_CLEAR;
`else
  localparam state_t RST_ST = S_IDLE;
`endif

  logic [31:0]   r_mem [DEPTH];
  state_t        r_state;
  state_t        w_next;
  logic [CW-1:0] r_cnt;
  logic [31:0]   r_hold;
  logic          r_hold_f;
  logic [31:0]   r_rdata;
  logic          r_fault;

  logic          w_ready;
  logic          w_valid;
  logic          w_acc;
  logic [AW-1:0] w_idx;
  logic          w_byte;
  logic          w_half;
  logic          w_word;
  logic          w_fault;
  logic [31:0]   w_rword;
  logic [7:0]    w_b;
  logic [15:0]   w_h;
  logic [31:0]   w_ext;
  logic [31:0]   w_res;
  logic [3:0]    w_be;
  logic [31:0]   w_wd;
  logic          w_unused;

  assign w_ready  = (r_state == S_IDLE);
  assign w_acc    = req_valid && w_ready && !reset;
  assign w_idx    = req_addr[AW+1:2];
  assign w_unused = ^req_addr;

  assign w_byte = (req_funct3[1:0] == 2'd0);
  assign w_half = (req_funct3[1:0] == 2'd1);
  assign w_word = (req_funct3 == 3'd2);

  // Bad width code, store with an unsigned width, or misaligned access.
  assign w_fault =
      (req_funct3 == 3'd3) || (req_funct3 == 3'd6) ||
      (req_funct3 == 3'd7) ||
      (req_we && req_funct3[2]) ||
      (w_half && req_addr[0]) ||
      (w_word && (req_addr[1:0] != 2'b00));

  assign w_rword = r_mem[w_idx];
  assign w_h     = req_addr[1] ? w_rword[31:16] : w_rword[15:0];

  // Pick the addressed byte lane of the read word.
  always_comb begin
    w_b = w_rword[7:0];
    case (req_addr[1:0])
      2'd1:    w_b = w_rword[15:8];
      2'd2:    w_b = w_rword[23:16];
      2'd3:    w_b = w_rword[31:24];
      default: w_b = w_rword[7:0];
    endcase
  end

  // Sign or zero extend the selected lane(s); funct3[2] marks unsigned.
  always_comb begin
    w_ext = w_rword;
    unique case (1'b1)
      w_byte: w_ext = req_funct3[2] ? {24'b0, w_b}
                                    : {{24{w_b[7]}}, w_b};
      w_half: w_ext = req_funct3[2] ? {16'b0, w_h}
                                    : {{16{w_h[15]}}, w_h};
      default: w_ext = w_rword;
    endcase
  end

  assign w_res = (w_fault || req_we) ? 32'b0 : w_ext;

  // Store lane enables and replicated store data.
  always_comb begin
    w_be = 4'b0000;
    w_wd = req_wdata;
    unique case (1'b1)
      w_byte: begin
        w_be = 4'b0001 << req_addr[1:0];
        w_wd = {4{req_wdata[7:0]}};
      end
      w_half: begin
        w_be = req_addr[1] ? 4'b1100 : 4'b0011;
        w_wd = {2{req_wdata[15:0]}};
      end
      w_word:  w_be = 4'b1111;
      default: w_be = 4'b0000;
    endcase
  end

`ifdef DMEM_CLEAR_EN
  logic [AW-1:0] r_clr;

  // Sweep index for the post-reset clear.
  always_ff @(posedge clock) begin
    if (reset) r_clr <= '0;
    else if (r_state == S_CLEAR) r_clr <= r_clr + 1'b1;
  end
`endif

  // Array writes: clear sweep, or a store at its accept edge.
  always_ff @(posedge clock) begin
`ifdef DMEM_CLEAR_EN
    if (!reset && r_state == S_CLEAR)
      r_mem[r_clr] <= '0;
    else
`endif
    if (w_acc && req_we && !w_fault) begin
      for (int i = 0; i < 4; i++) begin
        if (w_be[i])
          r_mem[w_idx][8*i +: 8] <= w_wd[8*i +: 8];
      end
    end
  end

  // State register.
  always_ff @(posedge clock) begin
    if (reset) r_state <= RST_ST;
    else       r_state <= w_next;
  end

  // Next-state and response strobe.
  always_comb begin
    w_next  = r_state;
    w_valid = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_acc)
          w_next = (LATENCY > 1) ? S_WAIT : S_RESP;
      end
      S_WAIT: begin
        if (r_cnt == CW'(1)) w_next = S_RESP;
      end
      S_RESP: begin
        w_valid = 1'b1;
        w_next  = S_IDLE;
      end
`ifdef DMEM_CLEAR_EN
      S_CLEAR: begin
        if (r_clr == AW'(DEPTH - 1)) w_next = S_IDLE;
      end
`endif
      default: w_next = S_IDLE;
    endcase
  end

  // Latency counter, held result, and response registers.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_cnt    <= '0;
      r_hold   <= '0;
      r_hold_f <= 1'b0;
      r_rdata  <= '0;
      r_fault  <= 1'b0;
    end else begin
      if (w_acc) begin
        r_cnt    <= CW'(LATENCY - 1);
        r_hold   <= w_res;
        r_hold_f <= w_fault;
      end else if (r_state == S_WAIT) begin
        r_cnt <= r_cnt - 1'b1;
      end
      if (w_next == S_RESP && r_state != S_RESP) begin
        r_rdata <= (r_state == S_IDLE) ? w_res : r_hold;
        r_fault <= (r_state == S_IDLE) ? w_fault : r_hold_f;
      end
    end
  end

  assign req_ready = w_ready;
  assign rsp_valid = w_valid;
  assign rsp_rdata = r_rdata;
  assign rsp_fault = r_fault;

endmodule

// File: tb/tb_dmem_lsu.sv
// tb_dmem_lsu: directed bench for dmem_lsu, one LATENCY=1 and
// one LATENCY=4 instance sharing clock and reset.
module tb_dmem_lsu;

  logic        clock = 1'b0;
  logic        reset;

  logic        a_valid, a_ready, a_we;
  logic [2:0]  a_f3;
  logic [31:0] a_addr, a_wdata;
  logic        a_rvalid, a_fault;
  logic [31:0] a_rdata;

  logic        b_valid, b_ready, b_we;
  logic [2:0]  b_f3;
  logic [31:0] b_addr, b_wdata;
  logic        b_rvalid, b_fault;
  logic [31:0] b_rdata;

  int n_asrt = 0;
  int n_fail = 0;

  always #5 clock = ~clock;

  dmem_lsu #(.DEPTH(256), .LATENCY(1), .ADDR_W(32)) u1 (
    .clock(clock), .reset(reset),
    .req_valid(a_valid), .req_ready(a_ready),
    .req_we(a_we), .req_funct3(a_f3),
    .req_addr(a_addr), .req_wdata(a_wdata),
    .rsp_valid(a_rvalid), .rsp_rdata(a_rdata),
    .rsp_fault(a_fault)
  );

  dmem_lsu #(.DEPTH(256), .LATENCY(4), .ADDR_W(32)) u4 (
    .clock(clock), .reset(reset),
    .req_valid(b_valid), .req_ready(b_ready),
    .req_we(b_we), .req_funct3(b_f3),
    .req_addr(b_addr), .req_wdata(b_wdata),
    .rsp_valid(b_rvalid), .rsp_rdata(b_rdata),
    .rsp_fault(b_fault)
  );

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    n_asrt++;
    assert (obs === exp) else begin
      n_fail++;
      $display("FAIL %s: observed %h expected %h", tag, obs, exp);
      $error("%s observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One request on the LATENCY=1 instance, response and hold checked.
  task automatic req1(input string tag, input logic we,
                      input logic [2:0] f3, input logic [31:0] addr,
                      input logic [31:0] wd, input logic [31:0] ed,
                      input logic ef);
    @(negedge clock);
    a_we = we; a_f3 = f3; a_addr = addr; a_wdata = wd;
    a_valid = 1'b1;
    chk({tag, ":ready"}, 32'(a_ready), 32'd1);
    @(posedge clock);
    #1;
    a_valid = 1'b0;
    chk({tag, ":valid"}, 32'(a_rvalid), 32'd1);
    chk({tag, ":rdata"}, a_rdata, ed);
    chk({tag, ":fault"}, 32'(a_fault), 32'(ef));
    @(posedge clock);
    #1;
    chk({tag, ":drop"}, 32'(a_rvalid), 32'd0);
    chk({tag, ":hold"}, a_rdata, ed);
  endtask

  // Five samples after a LATENCY=4 accept edge: ready low for four,
  // rsp_valid only on the fourth.
  task automatic b_wait(input string tag, input logic [31:0] ed,
                        input logic ef);
    for (int k = 0; k < 5; k++) begin
      @(negedge clock);
      chk($sformatf("%s:ready%0d", tag, k),
          32'(b_ready), (k == 4) ? 32'd1 : 32'd0);
      chk($sformatf("%s:valid%0d", tag, k),
          32'(b_rvalid), (k == 3) ? 32'd1 : 32'd0);
      if (k == 3) begin
        chk({tag, ":rdata"}, b_rdata, ed);
        chk({tag, ":fault"}, 32'(b_fault), 32'(ef));
      end
    end
  endtask

  task automatic b_set(input logic we, input logic [2:0] f3,
                       input logic [31:0] addr, input logic [31:0] wd);
    b_we = we; b_f3 = f3; b_addr = addr; b_wdata = wd;
    b_valid = 1'b1;
  endtask

  initial begin
    int seen;
    reset = 1'b1;
    a_valid = 0; a_we = 0; a_f3 = 0; a_addr = 0; a_wdata = 0;
    b_valid = 0; b_we = 0; b_f3 = 0; b_addr = 0; b_wdata = 0;
    repeat (3) @(posedge clock);
    @(negedge clock);
    reset = 1'b0;

    chk("rst:a_ready", 32'(a_ready), 32'd1);
    chk("rst:a_valid", 32'(a_rvalid), 32'd0);
    chk("rst:a_rdata", a_rdata, 32'd0);
    chk("rst:a_fault", 32'(a_fault), 32'd0);
    chk("rst:b_ready", 32'(b_ready), 32'd1);
    chk("rst:b_valid", 32'(b_rvalid), 32'd0);

    req1("sw10", 1, 3'd2, 32'h10, 32'hDEADBEEF, 32'h0, 0);
    req1("lw10", 0, 3'd2, 32'h10, 32'h0, 32'hDEADBEEF, 0);
    req1("sb11", 1, 3'd0, 32'h11, 32'h12345680, 32'h0, 0);
    req1("lw10b", 0, 3'd2, 32'h10, 32'h0, 32'hDEAD80EF, 0);
    req1("lb11", 0, 3'd0, 32'h11, 32'h0, 32'hFFFFFF80, 0);
    req1("lbu11", 0, 3'd4, 32'h11, 32'h0, 32'h00000080, 0);
    req1("lh12", 0, 3'd1, 32'h12, 32'h0, 32'hFFFFDEAD, 0);
    req1("lhu12", 0, 3'd5, 32'h12, 32'h0, 32'h0000DEAD, 0);

    req1("sw00", 1, 3'd2, 32'h00, 32'hCAFEF00D, 32'h0, 0);
    req1("lh13", 0, 3'd1, 32'h13, 32'h0, 32'h0, 1);
    req1("lw12", 0, 3'd2, 32'h12, 32'h0, 32'h0, 1);
    req1("sw01", 1, 3'd2, 32'h01, 32'h11111111, 32'h0, 1);
    req1("f3_3", 0, 3'd3, 32'h00, 32'h0, 32'h0, 1);
    req1("sbu", 1, 3'd4, 32'h00, 32'h22222222, 32'h0, 1);
    req1("lw00", 0, 3'd2, 32'h00, 32'h0, 32'hCAFEF00D, 0);

    req1("sh02", 1, 3'd1, 32'h02, 32'hAAAA5555, 32'h0, 0);
    req1("lw00b", 0, 3'd2, 32'h00, 32'h0, 32'h5555F00D, 0);
    req1("lb03", 0, 3'd0, 32'h03, 32'h0, 32'h00000055, 0);
    req1("lh00", 0, 3'd1, 32'h00, 32'h0, 32'hFFFFF00D, 0);

    req1("sw400", 1, 3'd2, 32'h400, 32'h12345678, 32'h0, 0);
    req1("lwwrap", 0, 3'd2, 32'h0, 32'h0, 32'h12345678, 0);

    // Back-to-back requests with req_valid held high throughout.
    @(negedge clock);
    b_set(1, 3'd2, 32'h20, 32'h01020304);
    @(posedge clock);
    b_wait("b_sw20", 32'h0, 0);
    b_set(0, 3'd2, 32'h20, 32'h0);
    @(posedge clock);
    b_wait("b_lw20", 32'h01020304, 0);
    b_set(0, 3'd5, 32'h22, 32'h0);
    @(posedge clock);
    b_wait("b_lhu22", 32'h00000102, 0);
    b_set(0, 3'd0, 32'h23, 32'h0);
    @(posedge clock);
    b_wait("b_lb23", 32'h00000001, 0);
    b_set(0, 3'd2, 32'h21, 32'h0);
    @(posedge clock);
    b_wait("b_lw21", 32'h0, 1);
    b_valid = 1'b0;

    // Reset while a store waits for its response.
    @(negedge clock);
    b_set(1, 3'd2, 32'h40, 32'hA5A5A5A5);
    @(posedge clock);
    #1;
    b_valid = 1'b0;
    @(negedge clock);
    chk("rw:in_wait", 32'(b_ready), 32'd0);
    reset = 1'b1;
    @(posedge clock);
    @(negedge clock);
    reset = 1'b0;
    chk("rw:ready", 32'(b_ready), 32'd1);
    chk("rw:rdata", b_rdata, 32'd0);
    chk("rw:fault", 32'(b_fault), 32'd0);
    seen = 0;
    for (int k = 0; k < 6; k++) begin
      if (b_rvalid) seen++;
      @(negedge clock);
    end
    chk("rw:no_rsp", 32'(seen), 32'd0);
    b_set(0, 3'd2, 32'h40, 32'h0);
    @(posedge clock);
    b_wait("rw_lw40", 32'hA5A5A5A5, 0);
    b_valid = 1'b0;

    repeat (2) @(negedge clock);
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_asrt, n_fail);
    $finish;
  end

endmodule

// File: doc/dmem_lsu.md
Name: dmem_lsu

Overview:
- Parametrised data memory for the RISC-V core. Successor to the single-word memory.
- Adds a byte-addressed request/response handshake, RV32I load/store widths (byte, half, word), sign/zero extension, misalignment and illegal-width faults, and a configurable read latency.
- Sits between the core's MEM stage and the data array.
- One transaction outstanding at a time.

Parameters:
- DEPTH, 256, number of 32-bit words; power of two, >= 2.
- LATENCY, 1, cycles from the accept edge to rsp_valid; must be >= 1.
- ADDR_W, 32, width of the byte address.

Ports:
- clock  input  1  system clock, rising edge.
- reset  input  1  synchronous, active-high.
- req_valid  input  1  request present.
- req_ready  output  1  block can accept a request.
- req_we  input  1  1 = store, 0 = load.
- req_funct3  input  3  RV32I width: 0 LB/SB, 1 LH/SH, 2 LW/SW, 4 LBU, 5 LHU.
- req_addr  input  ADDR_W  byte address.
- req_wdata  input  32  store data; low bits used for SB/SH.
- rsp_valid  output  1  one-cycle response pulse.
- rsp_rdata  output  32  load result, extended to 32 bits.
- rsp_fault  output  1  request was misaligned or illegal; qualified by rsp_valid.

Behaviour:
- Clock and reset: reset reset, synchronous, active-high; clock clock.
- Reset values: state IDLE, req_ready 1, rsp_valid 0, rsp_rdata 0, rsp_fault 0, latency counter 0. Array contents are not cleared unless the optional feature is enabled.
- Accept: a request is accepted on the rising edge where req_valid && req_ready.
- Ready rule: req_ready is 1 only in IDLE, so throughput is one request per LATENCY+1 cycles.
- Word index: req_addr[log2(DEPTH)+1:2]. Upper address bits are ignored, so addresses wrap modulo DEPTH*4.
- Fault conditions:
  - Half access (funct3 1 or 5) with addr[0] = 1.
  - Word access (funct3 2) with addr[1:0] != 0.
  - funct3 in {3, 6, 7}.
  - Store with funct3 in {4, 5}.
- On fault: no array write, rsp_rdata = 0, rsp_fault = 1.
- Store: commits at the accept edge.
  - SB writes lane addr[1:0] with wdata[7:0].
  - SH writes lanes {addr[1],0} and {addr[1],1} with wdata[15:0].
  - SW writes all four lanes.
  - Other lanes are unchanged.
  - Response: rsp_rdata = 0, rsp_fault = 0.
- Load: the word is read at the accept edge and the selected lane(s) are extracted.
  - LB and LH sign-extend.
  - LBU and LHU zero-extend.
  - The result is held internally until the response.
- FSM:
  - IDLE: on accept, go to WAIT with counter = LATENCY-1 if LATENCY > 1, otherwise go to RESP.
  - WAIT: decrement the counter; when it reaches 0, go to RESP.
  - RESP: rsp_valid = 1 for exactly one cycle, then return to IDLE.
- Timing: rsp_valid is asserted in the cycle LATENCY clocks after the accept edge.
- Output hold: rsp_rdata and rsp_fault update only when entering RESP. They hold their value until the next response.
- Reset mid-operation: any pending response is dropped and the FSM returns to IDLE. A store already committed at its accept edge remains in the array.
- Ignored inputs: req_valid while req_ready = 0 has no effect.

Optional Feature:
- Macro: DMEM_CLEAR_EN.
- When defined:
  - A CLEAR state is entered on the first cycle after reset deasserts.
  - CLEAR writes 0 to word 0 through DEPTH-1, one word per cycle.
  - req_ready = 0 for exactly DEPTH cycles, then the FSM enters IDLE.
  - Reset asserted during CLEAR restarts the sweep from word 0 after release.
- When undefined:
  - The FSM enters IDLE directly after reset.
  - Array contents are undefined until written.

Test Plan:
- LATENCY=1. SW addr 0x10 data 0xDEADBEEF, then LW addr 0x10 -> store rsp_valid 1 cycle after accept with fault 0. Load rsp_rdata = 0xDEADBEEF.
- SB addr 0x11 data 0x80 over 0xDEADBEEF, then LB 0x11 and LBU 0x11 -> word reads 0xDEAD80EF. LB returns 0xFFFFFF80. LBU returns 0x00000080.
- LH addr 0x13, LW addr 0x12, SW addr 0x01, funct3 = 3 -> each gives rsp_fault = 1 and rsp_rdata = 0. The word at 0x00 is unchanged.
- LATENCY=4, back-to-back req_valid -> rsp_valid appears 4 cycles after each accept. req_ready is low for 4 cycles after each accept, so accepts are 5 cycles apart.
- DEPTH=256. SW addr 0x400 data 0x12345678, then LW addr 0x0 -> returns 0x12345678 (address wrap).
- Reset asserted in WAIT after an SW is accepted -> no rsp_valid is produced. A subsequent LW of the same address returns the stored data. With DMEM_CLEAR_EN defined, req_ready stays low for DEPTH cycles after release and any LW afterwards returns 0.
